// File: rtl/gpio_led_driver.sv
// Four-LED driver fed by the PS GPIO word. Each byte selects OFF/ON/BLINK/PWM for one LED.
// Control bytes are latched only at PWM frame boundaries, so LEDs never glitch mid-frame.

module gpio_led_lane (
    input  logic       CLK,
    input  logic       RST,
    input  logic       frame_end,
    input  logic [7:0] ctrl,
    input  logic [5:0] pwm_cnt,
    output logic       led
);
    localparam logic [1:0] MODE_OFF   = 2'b00;
    localparam logic [1:0] MODE_ON    = 2'b01;
    localparam logic [1:0] MODE_BLINK = 2'b10;

    logic [7:0] shadow;
    logic [5:0] blink_cnt;
    logic       phase;
    logic       led_d;

    logic [1:0] mode, new_mode;
    logic [5:0] val;

    assign mode     = shadow[7:6];
    assign val      = shadow[5:0];
    assign new_mode = ctrl[7:6];

    always_comb begin
        led_d = 1'b0;
        case (mode)
            MODE_OFF:   led_d = 1'b0;
            MODE_ON:    led_d = 1'b1;
            MODE_BLINK: led_d = phase;
            default:    led_d = (pwm_cnt < val);
        endcase
    end

    // A mode change outranks blink expiry; >= copes with val shrinking mid-blink.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            shadow    <= '0;
            blink_cnt <= '0;
            phase     <= 1'b0;
            led       <= 1'b0;
        end else begin
            led <= led_d;
            if (frame_end) begin
                shadow <= ctrl;
                if (new_mode != mode) begin
                    blink_cnt <= '0;
                    phase     <= 1'b0;
                end else if (mode == MODE_BLINK) begin
                    if (blink_cnt >= val) begin
                        blink_cnt <= '0;
                        phase     <= ~phase;
                    end else begin
                        blink_cnt <= blink_cnt + 6'd1;
                    end
                end
            end
        end
    end
endmodule

module gpio_led_driver #(
    parameter int PRESC_DIV = 1563
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [31:0] gpio_ctrl,
    output logic [3:0]  led,
    output logic        frame_strobe
);
    localparam int NUM_LANES = 4;
    localparam int PW        = (PRESC_DIV > 1) ? $clog2(PRESC_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(PRESC_DIV - 1);

    logic [PW-1:0] prescaler;
    logic [5:0]    pwm_cnt;
    logic          tick, frame_end;

    assign tick      = (prescaler == PRESC_LAST);
    assign frame_end = tick && (pwm_cnt == 6'd63);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            prescaler    <= '0;
            pwm_cnt      <= '0;
            frame_strobe <= 1'b0;
        end else begin
            prescaler    <= tick ? '0 : prescaler + PW'(1);
            frame_strobe <= frame_end;
            if (tick)
                pwm_cnt <= pwm_cnt + 6'd1;
        end
    end

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        gpio_led_lane u_lane (
            .CLK       (CLK),
            .RST       (RST),
            .frame_end (frame_end),
            .ctrl      (gpio_ctrl[8*i +: 8]),
            .pwm_cnt   (pwm_cnt),
            .led       (led[i])
        );
    end
endmodule

// File: tb/tb_gpio_led_driver.sv
// Directed bench for gpio_led_driver: a per-cycle reference model feeds a scoreboard queue,
// plus waveform-level checks (duty counts, blink periods, latch latency, reset behaviour).

module tb_gpio_led_driver;
    localparam int PD = 2;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [31:0] gpio_ctrl = '0;
    logic [3:0]  led;
    logic        frame_strobe;

    gpio_led_driver #(.PRESC_DIV(PD)) dut (
        .CLK          (CLK),
        .RST          (RST),
        .gpio_ctrl    (gpio_ctrl),
        .led          (led),
        .frame_strobe (frame_strobe)
    );

    always #5 CLK = ~CLK;

    int passes = 0;
    int total  = 0;
    int cyc    = 0;

    // reference model state
    int          m_pre, m_pwm;
    logic [31:0] m_sh;
    int          m_cnt [4];
    logic [3:0]  m_ph;
    logic [4:0]  exp_q [$];

    logic        obs_fs;
    logic [3:0]  obs_led;
    int          hi [4];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
        total++;
        assert (got === expv) passes++;
        else $error("FAIL %s: got %0h expected %0h", tag, got, expv);
    endtask

    task automatic model_reset();
        m_pre = 0; m_pwm = 0; m_sh = '0; m_ph = '0;
        for (int i = 0; i < 4; i++) m_cnt[i] = 0;
        exp_q.delete();
    endtask

    // One clock: predict outputs after the coming edge, then compare after it.
    task automatic step();
        logic       fe;
        logic [3:0] nl;
        logic [1:0] md, nmd;
        int         v;
        logic [4:0] expv;
        fe = (m_pre == PD-1) && (m_pwm == 63);
        for (int i = 0; i < 4; i++) begin
            md = m_sh[8*i+6 +: 2];
            v  = int'(m_sh[8*i +: 6]);
            case (md)
                2'b00:   nl[i] = 1'b0;
                2'b01:   nl[i] = 1'b1;
                2'b10:   nl[i] = m_ph[i];
                default: nl[i] = (m_pwm < v);
            endcase
            if (fe) begin
                nmd = gpio_ctrl[8*i+6 +: 2];
                if (nmd != md) begin
                    m_cnt[i] = 0; m_ph[i] = 1'b0;
                end else if (md == 2'b10 && m_cnt[i] >= v) begin
                    m_cnt[i] = 0; m_ph[i] = ~m_ph[i];
                end else if (md == 2'b10) begin
                    m_cnt[i]++;
                end
            end
        end
        if (fe) m_sh = gpio_ctrl;
        if (m_pre == PD-1) begin
            m_pre = 0;
            m_pwm = (m_pwm + 1) % 64;
        end else begin
            m_pre++;
        end
        exp_q.push_back({fe, nl});
        @(posedge CLK); #1;
        expv = exp_q.pop_front();
        check("cycle_outputs", {27'd0, frame_strobe, led}, {27'd0, expv});
        obs_fs  = frame_strobe;
        obs_led = led;
        cyc++;
    endtask

    task automatic run_count(input int n);
        for (int i = 0; i < 4; i++) hi[i] = 0;
        for (int k = 0; k < n; k++) begin
            step();
            for (int i = 0; i < 4; i++) hi[i] += int'(obs_led[i]);
        end
    endtask

    task automatic wait_strobe(input string tag);
        int k = 0;
        do begin
            step();
            k++;
        end while (!obs_fs && k < 300);
        check(tag, {31'd0, obs_fs}, 32'd1);
    endtask

    task automatic wait_pwm(input int v);
        int k = 0;
        while (!(m_pwm == v && m_pre == 0) && k < 300) begin
            step();
            k++;
        end
        check("wait_pwm_bound", {31'd0, (m_pwm == v && m_pre == 0)}, 32'd1);
    endtask

    initial begin
        int t0;
        model_reset();
        repeat (2) @(posedge CLK);
        #1;
        check("reset_led", {28'd0, led}, 32'd0);
        check("reset_strobe", {31'd0, frame_strobe}, 32'd0);
        RST = 1'b0;

        // latch timing: write mid-frame, takes effect only after frame_end
        wait_pwm(10);
        gpio_ctrl = 32'h0000_0040;
        wait_strobe("latch_strobe");
        check("latch_led_at_strobe", {31'd0, obs_led[0]}, 32'd0);
        step();
        check("latch_led_after", {31'd0, obs_led[0]}, 32'd1);

        // PWM duty
        gpio_ctrl = 32'h0000_00D0;
        wait_strobe("pwm16_strobe");
        run_count(128);
        check("pwm16_duty", hi[0], 32);
        gpio_ctrl = 32'h0000_00C0;
        wait_strobe("pwm0_strobe");
        run_count(128);
        check("pwm0_duty", hi[0], 0);
        gpio_ctrl = 32'h0000_00FF;
        wait_strobe("pwm63_strobe");
        run_count(128);
        check("pwm63_duty", hi[0], 126);

        // blink, val=2 -> 3-frame half period starting low
        gpio_ctrl = 32'h0000_0082;
        wait_strobe("blink_strobe");
        run_count(384);
        check("blink_low", hi[0], 0);
        run_count(256);
        check("blink_high", hi[0], 256);
        gpio_ctrl = 32'h0000_0040;
        wait_strobe("blink_to_on_strobe");
        step();
        check("blink_to_on", {31'd0, obs_led[0]}, 32'd1);
        gpio_ctrl = 32'h0000_0082;
        wait_strobe("blink_restart_strobe");
        run_count(384);
        check("blink_restart_low", hi[0], 0);
        run_count(128);
        check("blink_restart_high", hi[0], 128);

        // mixed word
        gpio_ctrl = 32'h40C8_8200;
        wait_strobe("mixed_strobe");
        run_count(384);
        check("mixed_led3", hi[3], 384);
        check("mixed_led2", hi[2], 48);
        check("mixed_led1_low", hi[1], 0);
        check("mixed_led0", hi[0], 0);
        run_count(384);
        check("mixed_led1_high", hi[1], 384);

        // glitch rejection
        gpio_ctrl = 32'h0;
        wait_strobe("glitch_clear_strobe");
        wait_pwm(10);
        gpio_ctrl = 32'h4040_4040;
        repeat (10) step();
        gpio_ctrl = 32'h0;
        wait_strobe("glitch_strobe_a");
        t0 = cyc;
        run_count(127);
        check("glitch_led_quiet", hi[0] + hi[1] + hi[2] + hi[3], 0);
        wait_strobe("glitch_strobe_b");
        check("strobe_period", cyc - t0, 128);

        // async reset mid-operation
        gpio_ctrl = 32'h0000_0040;
        wait_strobe("rst_pre_strobe");
        step();
        check("rst_pre_led", {31'd0, obs_led[0]}, 32'd1);
        repeat (50) step();
        #2 RST = 1'b1;
        #1;
        check("rst_async_led", {28'd0, led}, 32'd0);
        check("rst_async_strobe", {31'd0, frame_strobe}, 32'd0);
        model_reset();
        @(posedge CLK); #1;
        RST = 1'b0;
        run_count(128);
        check("rst_release_dark", hi[0], 0);
        check("rst_release_strobe", {31'd0, obs_fs}, 32'd1);
        step();
        check("rst_release_led", {31'd0, obs_led[0]}, 32'd1);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end
endmodule
